// File: rtl/key_pkg.sv
// Shared types and constants for the keypad scanner: FSM encoding, default
// prescaler/debounce settings and the sixteen key codes.
package key_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDebounce,
        StHeld
    } state_e;

    localparam int unsigned DefaultDiv  = 100_000;
    localparam int unsigned DefaultDebN = 4;

    // key_code = {row_idx, col_idx}
    localparam logic [3:0] KeyR0C0 = 4'h0;
    localparam logic [3:0] KeyR0C1 = 4'h1;
    localparam logic [3:0] KeyR0C2 = 4'h2;
    localparam logic [3:0] KeyR0C3 = 4'h3;
    localparam logic [3:0] KeyR1C0 = 4'h4;
    localparam logic [3:0] KeyR1C1 = 4'h5;
    localparam logic [3:0] KeyR1C2 = 4'h6;
    localparam logic [3:0] KeyR1C3 = 4'h7;
    localparam logic [3:0] KeyR2C0 = 4'h8;
    localparam logic [3:0] KeyR2C1 = 4'h9;
    localparam logic [3:0] KeyR2C2 = 4'hA;
    localparam logic [3:0] KeyR2C3 = 4'hB;
    localparam logic [3:0] KeyR3C0 = 4'hC;
    localparam logic [3:0] KeyR3C1 = 4'hD;
    localparam logic [3:0] KeyR3C2 = 4'hE;
    localparam logic [3:0] KeyR3C3 = 4'hF;

    function automatic logic [1:0] lowest_zero(input logic [3:0] v);
        if (!v[0]) begin
            lowest_zero = 2'd0;
        end else if (!v[1]) begin
            lowest_zero = 2'd1;
        end else if (!v[2]) begin
            lowest_zero = 2'd2;
        end else begin
            lowest_zero = 2'd3;
        end
    endfunction

endpackage

// File: rtl/key_scan_if.sv
// Keypad-side and report signals of the scanner; slave is the scanner itself.
interface key_scan_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;

    modport master (
        output col_n,
        input  row_n,
        input  key_code,
        input  key_valid,
        input  key_down
    );

    modport slave (
        input  col_n,
        output row_n,
        output key_code,
        output key_valid,
        output key_down
    );
endinterface

// File: rtl/scan_tick.sv
// Free-running prescaler: counts 0..DIV-1 and pulses tick at DIV-1.
module scan_tick
    import key_pkg::*;
#(
    parameter int unsigned DIV = DefaultDiv
) (
    input  logic clk_50m,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    always_comb begin
        tick  = (cnt_q == CntMax);
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_scan.sv
// 4x4 keypad scanner: synchronizes columns, walks rows on each tick, debounces
// press and release and reports one key_valid pulse per debounced press.
module key_scan
    import key_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned SCAN_HZ = 500,
    parameter int unsigned DEB_N   = DefaultDebN
) (
    input  logic       clk_50m,
    input  logic       rst,
    key_scan_if.slave  bus
);

    localparam int unsigned DIV  = CLK_HZ / SCAN_HZ;
    localparam int unsigned CntW = $clog2(DEB_N + 1);
    localparam logic [CntW-1:0] CntTop  = CntW'(DEB_N);
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_N - 1);

    logic            tick;
    logic [3:0]      col_meta_q, col_s_q;
    state_e          state_d, state_q;
    logic [1:0]      row_idx_d, row_idx_q;
    logic [1:0]      col_idx_d, col_idx_q;
    logic [CntW-1:0] deb_cnt_d, deb_cnt_q;
    logic [CntW-1:0] rel_cnt_d, rel_cnt_q;
    logic [3:0]      key_code_d, key_code_q;
    logic            key_valid_d, key_valid_q;

    scan_tick #(
        .DIV (DIV)
    ) u_scan_tick (
        .clk_50m (clk_50m),
        .rst     (rst),
        .tick    (tick)
    );

    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        deb_cnt_d   = deb_cnt_q;
        rel_cnt_d   = rel_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (tick && col_s_q != 4'b1111) begin
                    state_d   = StScan;
                    row_idx_d = 2'd0;
                end
            end
            StScan: begin
                if (tick) begin
                    if (col_s_q != 4'b1111) begin
                        col_idx_d = lowest_zero(col_s_q);
                        deb_cnt_d = CntW'(1);
                        state_d   = StDebounce;
                        // A single-tick debounce reports on the detection tick itself.
                        if (DEB_N <= 1) begin
                            key_code_d  = {row_idx_q, lowest_zero(col_s_q)};
                            key_valid_d = 1'b1;
                            rel_cnt_d   = '0;
                            state_d     = StHeld;
                        end
                    end else if (row_idx_q == 2'd3) begin
                        row_idx_d = 2'd0;
                        state_d   = StIdle;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
            end
            StDebounce: begin
                if (tick) begin
                    if (!col_s_q[col_idx_q]) begin
                        if (deb_cnt_q < CntTop) begin
                            deb_cnt_d = deb_cnt_q + CntW'(1);
                        end
                        if (deb_cnt_q >= CntLast) begin
                            key_code_d  = {row_idx_q, col_idx_q};
                            key_valid_d = 1'b1;
                            rel_cnt_d   = '0;
                            state_d     = StHeld;
                        end
                    end else begin
                        deb_cnt_d = '0;
                        state_d   = StIdle;
                    end
                end
            end
            StHeld: begin
                if (tick) begin
                    if (col_s_q[col_idx_q]) begin
                        if (rel_cnt_q < CntTop) begin
                            rel_cnt_d = rel_cnt_q + CntW'(1);
                        end
                        if (rel_cnt_q >= CntLast) begin
                            rel_cnt_d = '0;
                            deb_cnt_d = '0;
                            state_d   = StIdle;
                        end
                    end else begin
                        rel_cnt_d = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            col_meta_q  <= 4'b1111;
            col_s_q     <= 4'b1111;
            state_q     <= StIdle;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            deb_cnt_q   <= '0;
            rel_cnt_q   <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            col_meta_q  <= bus.col_n;
            col_s_q     <= col_meta_q;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            deb_cnt_q   <= deb_cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign bus.row_n     = (state_q == StIdle) ? 4'b0000 : ~(4'b0001 << row_idx_q);
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_down  = (state_q == StHeld);

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with a passive keypad model and a key_code scoreboard.
module tb_key_scan;
    import key_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  col_model;

    int n_assert = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    logic [3:0] exp_q[$];

    key_scan_if kb ();

    key_scan #(
        .CLK_HZ  (8),
        .SCAN_HZ (2),
        .DEB_N   (4)
    ) dut (
        .clk_50m (clk),
        .rst     (rst),
        .bus     (kb)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its column to its row; columns are pulled up.
    always_comb begin
        col_model = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kb.row_n[r]) begin
                    col_model[c] = 1'b0;
                end
            end
        end
    end
    assign kb.col_n = col_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_down(input logic val, input int budget, output int clocks);
        clocks = 0;
        while (kb.key_down !== val && clocks < budget) begin
            @(negedge clk);
            clocks++;
        end
    endtask

    // Scoreboard side: every key_valid pops one expected code.
    initial begin
        logic prev_valid;
        logic [3:0] exp_code;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (kb.key_valid === 1'b1) begin
                valid_cnt++;
                check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
                check("valid_expected", {31'd0, (exp_q.size() != 0)}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_code = exp_q.pop_front();
                    check("key_code_sb", {28'd0, kb.key_code}, {28'd0, exp_code});
                end
            end
            prev_valid = kb.key_valid;
        end
    end

    initial begin
        int n;
        int m;
        int v0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_row_n", {28'd0, kb.row_n}, 32'h0);
        check("rst_key_code", {28'd0, kb.key_code}, 32'h0);
        check("rst_key_valid", {31'd0, kb.key_valid}, 32'h0);
        check("rst_key_down", {31'd0, kb.key_down}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Clean press of row 2 col 1, held 40 clocks
        v0 = valid_cnt;
        exp_q.push_back(KeyR2C1);
        pressed = 16'h0200;
        wait_down(1'b1, 100, n);
        check("press_key_down", {31'd0, kb.key_down}, 32'd1);
        check("press_latency", {31'd0, (n >= 26 && n <= 31)}, 32'd1);
        check("press_key_code", {28'd0, kb.key_code}, {28'd0, KeyR2C1});
        check("press_row_held", {28'd0, kb.row_n}, 32'hB);
        repeat (40 - n) @(negedge clk);
        pressed = 16'h0000;
        repeat (8) @(negedge clk);
        check("held_after_release", {31'd0, kb.key_down}, 32'd1);
        wait_down(1'b0, 30, m);
        check("release_key_down", {31'd0, kb.key_down}, 32'd0);
        check("release_latency", {31'd0, (8 + m >= 14 && 8 + m <= 19)}, 32'd1);
        check("release_row_n", {28'd0, kb.row_n}, 32'h0);
        check("key_code_holds", {28'd0, kb.key_code}, {28'd0, KeyR2C1});
        check("clean_valid_count", valid_cnt - v0, 32'd1);

        // Bounce on row 0 col 3 shorter than the debounce window
        v0 = valid_cnt;
        pressed = 16'h0008;
        repeat (8) @(negedge clk);
        pressed = 16'h0000;
        repeat (40) @(negedge clk);
        check("bounce_valid_count", valid_cnt - v0, 32'd0);
        check("bounce_row_n", {28'd0, kb.row_n}, 32'h0);
        check("bounce_key_down", {31'd0, kb.key_down}, 32'd0);

        // Two keys (1,2) and (3,0); lowest row wins, then the other after release
        v0 = valid_cnt;
        exp_q.push_back(KeyR1C2);
        pressed = 16'h1040;
        wait_down(1'b1, 100, n);
        check("two_key_down", {31'd0, kb.key_down}, 32'd1);
        check("two_key_code", {28'd0, kb.key_code}, {28'd0, KeyR1C2});
        repeat (8) @(negedge clk);
        exp_q.push_back(KeyR3C0);
        pressed = 16'h1000;
        wait_down(1'b0, 40, n);
        check("two_release", {31'd0, kb.key_down}, 32'd0);
        wait_down(1'b1, 100, n);
        check("rescan_key_down", {31'd0, kb.key_down}, 32'd1);
        check("rescan_key_code", {28'd0, kb.key_code}, {28'd0, KeyR3C0});
        pressed = 16'h0000;
        wait_down(1'b0, 40, n);
        check("rescan_release", {31'd0, kb.key_down}, 32'd0);
        check("two_valid_count", valid_cnt - v0, 32'd2);

        // Reset while debouncing row 0 col 0 with deb_cnt = 3
        v0 = valid_cnt;
        pressed = 16'h0001;
        n = 0;
        while (kb.row_n !== 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("scan_start_row_n", {28'd0, kb.row_n}, 32'hE);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_row_n", {28'd0, kb.row_n}, 32'h0);
        check("abort_key_code", {28'd0, kb.key_code}, 32'h0);
        check("abort_key_valid", {31'd0, kb.key_valid}, 32'd0);
        check("abort_key_down", {31'd0, kb.key_down}, 32'd0);
        pressed = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_valid_count", valid_cnt - v0, 32'd0);

        // Release chatter while held: 2 high ticks, 1 low, then 4 high
        v0 = valid_cnt;
        exp_q.push_back(KeyR2C1);
        pressed = 16'h0200;
        wait_down(1'b1, 100, n);
        check("chatter_press", {31'd0, kb.key_down}, 32'd1);
        pressed = 16'h0000;
        repeat (8) @(negedge clk);
        pressed = 16'h0200;
        repeat (4) @(negedge clk);
        pressed = 16'h0000;
        repeat (12) @(negedge clk);
        check("chatter_still_held", {31'd0, kb.key_down}, 32'd1);
        repeat (4) @(negedge clk);
        check("chatter_released", {31'd0, kb.key_down}, 32'd0);
        repeat (40) @(negedge clk);
        check("chatter_valid_count", valid_cnt - v0, 32'd1);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter CLK_HZ, 50_000_000, input clock frequency in Hz.
REQ-002 Parameter SCAN_HZ, 500, row-step/sample rate in Hz; DIV = CLK_HZ/SCAN_HZ clocks per tick.
REQ-003 Parameter DEB_N, 4, consecutive consistent ticks required for press and release debounce.
REQ-004 clk_50m  input  1  sole clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 col_n  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk_50m.
REQ-007 row_n  output  4  keypad row drive, active-low.
REQ-008 key_code  output  4  last debounced key, {row_idx[1:0], col_idx[1:0]}.
REQ-009 key_valid  output  1  one-clock pulse when a new debounced press is reported.
REQ-010 key_down  output  1  high while the reported key is held.

Function
REQ-011 col_n SHALL pass through a 2-flop synchronizer (col_s) before any use.
REQ-012 Prescaler SHALL count 0..DIV-1 and wrap; tick is a one-clock pulse at count DIV-1; all FSM decisions occur only on tick.
REQ-013 FSM states: IDLE, SCAN, DEBOUNCE, HELD.
REQ-014 IDLE: row_n = 4'b0000; on tick with col_s != 4'b1111, go SCAN with row_idx = 0, row_n = 4'b1110.
REQ-015 SCAN: row_n drives only row row_idx low; on tick, if col_s has any zero, capture col_idx = lowest-numbered zero column, deb_cnt = 1, go DEBOUNCE.
REQ-016 SCAN, tick, col_s = 4'b1111: row_idx = 3 -> IDLE (row_n = 4'b0000); else row_idx+1 with row_n rotated.
REQ-017 DEBOUNCE: row held; on tick, col_s[col_idx] = 0 increments deb_cnt; col_s[col_idx] = 1 -> IDLE, deb_cnt cleared.
REQ-018 When deb_cnt reaches DEB_N, SHALL load key_code = {row_idx, col_idx}, pulse key_valid for exactly one clock (the clock after that tick), enter HELD.
REQ-019 HELD: key_down = 1, row held; on tick col_s[col_idx] = 1 increments rel_cnt, = 0 clears rel_cnt; rel_cnt reaching DEB_N -> IDLE, key_down = 0.
REQ-020 Press-to-key_valid latency: detection tick plus DEB_N-1 further ticks plus 1 clock; bounce shorter than DEB_N ticks SHALL produce no key_valid.
REQ-021 Multiple simultaneous keys: only the first found (lowest row, then lowest column) is reported; no further key_valid until release completes and a new press is scanned.
REQ-022 key_code SHALL hold its value outside key_valid; counters SHALL saturate, never wrap.
REQ-023 DEB_N = 1 SHALL report on the detection tick; key_valid SHALL never assert outside DEBOUNCE->HELD.

Reset
REQ-024 On rst: state IDLE, prescaler 0, row_idx 0, deb_cnt 0, rel_cnt 0, synchronizer flops 4'b1111, row_n 4'b0000, key_code 4'h0, key_valid 0, key_down 0.
REQ-025 rst mid-debounce or mid-hold SHALL abort without a key_valid pulse; rst has priority over tick.

Structure
REQ-026 Shared package key_pkg SHALL hold the state encoding, default DIV/DEB_N constants and the 16 key_code constants.
REQ-027 Prescaler SHALL be one sub-module scan_tick (parameter DIV, ports clk_50m, rst, tick); the rest lives in key_scan.

Verification (CLK_HZ = 8, SCAN_HZ = 2 -> DIV = 4; DEB_N = 4; bench keypad model ties col to row when pressed)
REQ-028 Clean press row 2 col 1 held 40 clocks -> exactly one key_valid, key_code = 4'h9, key_down high until 4 release ticks after key released.
REQ-029 Bounce: row 0 col 3 low for 2 ticks then released -> no key_valid, FSM back in IDLE, row_n = 4'b0000.
REQ-030 Two keys (1,2) and (3,0) together -> key_code = 4'h6, one key_valid; releasing (1,2) only -> after 4 ticks IDLE, rescan reports 4'hC.
REQ-031 rst asserted during DEBOUNCE deb_cnt = 3 -> no key_valid, all outputs at reset values next clock.
REQ-032 Release chatter in HELD: 2 high ticks, 1 low, 4 high -> key_down drops only after final 4th high tick; no second key_valid.
